// File: rtl/rtc_time_core.sv
// rtc_time_core: HH:MM:SS time-of-day core with a prescaled 1 s tick, digit-wise SET editing and a blink strobe.
// Define RTC_TIME_CORE_H12_EN to present hours in 12-hour form with a PM flag (internal time stays 24-hour).
module rtc_time_core #(
  parameter int CLK_HZ   = 100000000,
  parameter int BLINK_HZ = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_mod,
  input  logic       left,
  input  logic       right,
  input  logic       up,
  input  logic       down,
  output logic [5:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       pm,
  output logic       editing,
  output logic [2:0] edit_pos,
  output logic       sec_tick,
  output logic       blink
);
  localparam int PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int BLINK_RAW  = CLK_HZ / (2 * BLINK_HZ);
  localparam int BLINK_HALF = (BLINK_RAW < 1) ? 1 : BLINK_RAW;
  localparam int BW         = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRESC_ZERO = PW'(0);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [BW-1:0] BLINK_MAX  = BW'(BLINK_HALF - 1);
  localparam logic [BW-1:0] BLINK_ZERO = BW'(0);
  localparam logic [BW-1:0] BLINK_ONE  = BW'(1);
`ifdef RTC_TIME_CORE_H12_EN
  localparam logic [5:0] HOURS_RST = 6'd12;
`else
  localparam logic [5:0] HOURS_RST = 6'd0;
`endif

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_SET = 1'b1} state_t;

  state_t        state_r, nxt_state_s;
  logic          set_mod_d_r;
  logic [PW-1:0] presc_r, nxt_presc_s;
  logic [BW-1:0] blink_cnt_r;
  logic          blink_r, sec_tick_r, nxt_tick_s;
  logic [2:0]    edit_pos_r, nxt_pos_s;
  logic [5:0]    live_h_r, live_m_r, live_s_r, nxt_lh_s, nxt_lm_s, nxt_ls_s;
  logic [5:0]    sh_h_r, sh_m_r, sh_s_r, nxt_sh_h_s, nxt_sh_m_s, nxt_sh_s_s;
  logic [5:0]    ed_h_s, ed_m_s, ed_s_s;
  logic [5:0]    disp_h_s, disp_m_s, disp_s_s, hr_out_s;
  logic          pm_out_s;

  // Minute/second digit edit: tens wrap 0..5, ones wrap 0..9.
  function automatic logic [5:0] edit_ms(input logic [5:0] v, input logic tens, input logic inc);
    logic [3:0] t, o;
    t = 4'(v / 6'd10);
    o = 4'(v % 6'd10);
    if (tens) begin
      if (inc) t = (t == 4'd5) ? 4'd0 : t + 4'd1;
      else     t = (t == 4'd0) ? 4'd5 : t - 4'd1;
    end else begin
      if (inc) o = (o == 4'd9) ? 4'd0 : o + 4'd1;
      else     o = (o == 4'd0) ? 4'd9 : o - 4'd1;
    end
    return ({2'b00, t} * 6'd10) + {2'b00, o};
  endfunction

  // Hour digit edit; a tens of 2 limits the ones digit to 0..3 and clamps it there.
  function automatic logic [5:0] edit_hr(input logic [5:0] v, input logic tens, input logic inc);
    logic [3:0] t, o, omax;
    t    = 4'(v / 6'd10);
    o    = 4'(v % 6'd10);
    omax = (t == 4'd2) ? 4'd3 : 4'd9;
    if (tens) begin
      if (inc) t = (t == 4'd2) ? 4'd0 : t + 4'd1;
      else     t = (t == 4'd0) ? 4'd2 : t - 4'd1;
      if ((t == 4'd2) && (o > 4'd3)) o = 4'd3;
      else                           o = o;
    end else begin
      if (inc) o = (o >= omax) ? 4'd0 : o + 4'd1;
      else     o = (o == 4'd0) ? omax : o - 4'd1;
    end
    return ({2'b00, t} * 6'd10) + {2'b00, o};
  endfunction

  function automatic logic [17:0] next_second(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
    logic [5:0] nh, nm, ns;
    if (s != 6'd59) begin
      nh = h;     nm = m;         ns = s + 6'd1;
    end else if (m != 6'd59) begin
      nh = h;     nm = m + 6'd1;  ns = 6'd0;
    end else begin
      nh = (h == 6'd23) ? 6'd0 : h + 6'd1;
      nm = 6'd0;  ns = 6'd0;
    end
    return {nh, nm, ns};
  endfunction

  // Shadow time with this cycle's up/down applied to the digit under the cursor.
  always_comb begin
    ed_h_s = sh_h_r;
    ed_m_s = sh_m_r;
    ed_s_s = sh_s_r;
    if (up ^ down) begin
      case (edit_pos_r)
        3'd0:    ed_s_s = edit_ms(sh_s_r, 1'b0, up);
        3'd1:    ed_s_s = edit_ms(sh_s_r, 1'b1, up);
        3'd2:    ed_m_s = edit_ms(sh_m_r, 1'b0, up);
        3'd3:    ed_m_s = edit_ms(sh_m_r, 1'b1, up);
        3'd4:    ed_h_s = edit_hr(sh_h_r, 1'b0, up);
        3'd5:    ed_h_s = edit_hr(sh_h_r, 1'b1, up);
        default: ed_s_s = sh_s_r;
      endcase
    end else begin
      ed_s_s = sh_s_r;
    end
  end

  // RUN/SET sequencing, prescaler, live and shadow time, cursor.
  always_comb begin
    nxt_state_s = state_r;
    nxt_presc_s = presc_r;
    nxt_tick_s  = 1'b0;
    nxt_pos_s   = edit_pos_r;
    nxt_lh_s    = live_h_r;
    nxt_lm_s    = live_m_r;
    nxt_ls_s    = live_s_r;
    nxt_sh_h_s  = sh_h_r;
    nxt_sh_m_s  = sh_m_r;
    nxt_sh_s_s  = sh_s_r;
    case (state_r)
      ST_RUN: begin
        if (set_mod && !set_mod_d_r) begin
          nxt_state_s = ST_SET;
          nxt_presc_s = PRESC_ZERO;
          nxt_pos_s   = 3'd0;
          nxt_sh_h_s  = live_h_r;
          nxt_sh_m_s  = live_m_r;
          nxt_sh_s_s  = live_s_r;
        end else if (presc_r == PRESC_MAX) begin
          nxt_presc_s = PRESC_ZERO;
          nxt_tick_s  = 1'b1;
          {nxt_lh_s, nxt_lm_s, nxt_ls_s} = next_second(live_h_r, live_m_r, live_s_r);
        end else begin
          nxt_presc_s = presc_r + PRESC_ONE;
        end
      end
      ST_SET: begin
        nxt_presc_s = PRESC_ZERO;
        nxt_sh_h_s  = ed_h_s;
        nxt_sh_m_s  = ed_m_s;
        nxt_sh_s_s  = ed_s_s;
        // Leaving SET commits the shadow including any edit made on the same cycle.
        if (!set_mod && set_mod_d_r) begin
          nxt_state_s = ST_RUN;
          nxt_lh_s    = ed_h_s;
          nxt_lm_s    = ed_m_s;
          nxt_ls_s    = ed_s_s;
        end else if (left && !right) begin
          nxt_pos_s = (edit_pos_r == 3'd5) ? 3'd0 : edit_pos_r + 3'd1;
        end else if (right && !left) begin
          nxt_pos_s = (edit_pos_r == 3'd0) ? 3'd5 : edit_pos_r - 3'd1;
        end else begin
          nxt_pos_s = edit_pos_r;
        end
      end
      default: nxt_state_s = ST_RUN;
    endcase
  end

  // Displayed time follows the shadow in SET and the live time in RUN.
  always_comb begin
    if (nxt_state_s == ST_SET) begin
      disp_h_s = nxt_sh_h_s;
      disp_m_s = nxt_sh_m_s;
      disp_s_s = nxt_sh_s_s;
    end else begin
      disp_h_s = nxt_lh_s;
      disp_m_s = nxt_lm_s;
      disp_s_s = nxt_ls_s;
    end
`ifdef RTC_TIME_CORE_H12_EN
    if (disp_h_s == 6'd0)      hr_out_s = 6'd12;
    else if (disp_h_s > 6'd12) hr_out_s = disp_h_s - 6'd12;
    else                       hr_out_s = disp_h_s;
    pm_out_s = (disp_h_s >= 6'd12);
`else
    hr_out_s = disp_h_s;
    pm_out_s = 1'b0;
`endif
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_RUN;
      set_mod_d_r <= 1'b0;
      presc_r     <= PRESC_ZERO;
      sec_tick_r  <= 1'b0;
      edit_pos_r  <= 3'd0;
      live_h_r    <= 6'd0;
      live_m_r    <= 6'd0;
      live_s_r    <= 6'd0;
      sh_h_r      <= 6'd0;
      sh_m_r      <= 6'd0;
      sh_s_r      <= 6'd0;
      hours       <= HOURS_RST;
      minutes     <= 6'd0;
      seconds     <= 6'd0;
      pm          <= 1'b0;
      editing     <= 1'b0;
    end else begin
      state_r     <= nxt_state_s;
      set_mod_d_r <= set_mod;
      presc_r     <= nxt_presc_s;
      sec_tick_r  <= nxt_tick_s;
      edit_pos_r  <= nxt_pos_s;
      live_h_r    <= nxt_lh_s;
      live_m_r    <= nxt_lm_s;
      live_s_r    <= nxt_ls_s;
      sh_h_r      <= nxt_sh_h_s;
      sh_m_r      <= nxt_sh_m_s;
      sh_s_r      <= nxt_sh_s_s;
      hours       <= hr_out_s;
      minutes     <= disp_m_s;
      seconds     <= disp_s_s;
      pm          <= pm_out_s;
      editing     <= (nxt_state_s == ST_SET);
    end
  end

  // Free-running blink square wave, independent of RUN/SET.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_r <= BLINK_ZERO;
      blink_r     <= 1'b0;
    end else if (blink_cnt_r == BLINK_MAX) begin
      blink_cnt_r <= BLINK_ZERO;
      blink_r     <= ~blink_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + BLINK_ONE;
    end
  end

  assign edit_pos = edit_pos_r;
  assign sec_tick = sec_tick_r;
  assign blink    = blink_r;
endmodule

// File: tb/tb_rtc_time_core.sv
// Self-checking bench for rtc_time_core: a seconds-of-day / digit-array model checked every cycle,
// plus directed literal checks of tick timing, rollover and digit editing.
module tb_rtc_time_core;
  localparam int CLK_HZ   = 10;
  localparam int BLINK_HZ = 2;
  localparam int HALF     = CLK_HZ / (2 * BLINK_HZ);

  logic       clk = 1'b0;
  logic       reset, set_mod, left, right, up, down;
  logic [5:0] hours, minutes, seconds;
  logic       pm, editing, sec_tick, blink;
  logic [2:0] edit_pos;

  int vectors = 0;
  int miscompares = 0;

  // Model: live time as seconds of day, shadow as six decimal digits (0 = sec ones .. 5 = hr tens).
  int m_live, m_pos, m_cnt, m_bn;
  int m_dig[6];
  bit m_set, m_prev, m_tick;
  bit chk_en = 1'b0;
  bit sm_lvl = 1'b0;

  rtc_time_core #(.CLK_HZ(CLK_HZ), .BLINK_HZ(BLINK_HZ)) dut (
    .clk(clk), .reset(reset), .set_mod(set_mod), .left(left), .right(right), .up(up), .down(down),
    .hours(hours), .minutes(minutes), .seconds(seconds), .pm(pm), .editing(editing),
    .edit_pos(edit_pos), .sec_tick(sec_tick), .blink(blink)
  );

  always #5 clk = ~clk;

  function automatic int hexp(input int h);
`ifdef RTC_TIME_CORE_H12_EN
    if (h == 0) return 12;
    else if (h > 12) return h - 12;
    else return h;
`else
    return h;
`endif
  endfunction

  function automatic int pmexp(input int h);
`ifdef RTC_TIME_CORE_H12_EN
    return (h >= 12) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic model_step(input bit r, input bit sm, input bit l, input bit rt, input bit u, input bit d);
    int mx;
    if (r) begin
      m_live = 0; m_pos = 0; m_cnt = 0; m_bn = 0;
      m_set = 1'b0; m_prev = 1'b0; m_tick = 1'b0;
    end else begin
      m_bn++;
      m_tick = 1'b0;
      if (!m_set) begin
        if (sm && !m_prev) begin
          m_set = 1'b1;
          m_dig[0] = m_live % 10;
          m_dig[1] = (m_live / 10) % 6;
          m_dig[2] = (m_live / 60) % 10;
          m_dig[3] = (m_live / 600) % 6;
          m_dig[4] = (m_live / 3600) % 10;
          m_dig[5] = m_live / 36000;
          m_pos = 0;
          m_cnt = 0;
        end else begin
          m_cnt++;
          if (m_cnt == CLK_HZ) begin
            m_cnt = 0;
            m_tick = 1'b1;
            m_live = (m_live + 1) % 86400;
          end
        end
      end else begin
        if (u != d) begin
          case (m_pos)
            0, 2:    mx = 9;
            1, 3:    mx = 5;
            4:       mx = (m_dig[5] == 2) ? 3 : 9;
            default: mx = 2;
          endcase
          if (u) m_dig[m_pos] = (m_dig[m_pos] >= mx) ? 0 : m_dig[m_pos] + 1;
          else   m_dig[m_pos] = (m_dig[m_pos] == 0) ? mx : m_dig[m_pos] - 1;
          if (m_pos == 5 && m_dig[5] == 2 && m_dig[4] > 3) m_dig[4] = 3;
        end
        if (!sm && m_prev) begin
          m_set = 1'b0;
          m_live = (m_dig[5] * 10 + m_dig[4]) * 3600 + (m_dig[3] * 10 + m_dig[2]) * 60 + m_dig[1] * 10 + m_dig[0];
          m_cnt = 0;
        end else if (l && !rt) begin
          m_pos = (m_pos + 1) % 6;
        end else if (rt && !l) begin
          m_pos = (m_pos + 5) % 6;
        end
      end
      m_prev = sm;
    end
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    int eh, em, es;
    logic [24:0] exp_v, act_v;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (m_set) begin
          eh = m_dig[5] * 10 + m_dig[4]; em = m_dig[3] * 10 + m_dig[2]; es = m_dig[1] * 10 + m_dig[0];
        end else begin
          eh = m_live / 3600; em = (m_live / 60) % 60; es = m_live % 60;
        end
        exp_v = {6'(hexp(eh)), 6'(em), 6'(es), 1'(pmexp(eh)), m_set, 3'(m_pos), m_tick, 1'((m_bn / HALF) % 2)};
        act_v = {hours, minutes, seconds, pm, editing, edit_pos, sec_tick, blink};
        vectors++;
        if (act_v !== exp_v) begin
          miscompares++;
          $display("FAIL cycle t=%0t: got h=%0d m=%0d s=%0d pm=%0b ed=%0b pos=%0d tick=%0b blink=%0b, want h=%0d m=%0d s=%0d pm=%0b ed=%0b pos=%0d tick=%0b blink=%0b",
                   $time, act_v[24:19], act_v[18:13], act_v[12:7], act_v[6], act_v[5], act_v[4:2], act_v[1], act_v[0],
                   exp_v[24:19], exp_v[18:13], exp_v[12:7], exp_v[6], exp_v[5], exp_v[4:2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit sm, input bit l, input bit rt, input bit u, input bit d);
    reset = r; set_mod = sm; left = l; right = rt; up = u; down = d;
    @(posedge clk);
    model_step(r, sm, l, rt, u, d);
    chk_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic act(input bit l, input bit rt, input bit u, input bit d);
    cyc(1'b0, sm_lvl, l, rt, u, d);
  endtask

  task automatic set_lvl(input bit v);
    sm_lvl = v;
    act(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_digit(input int p, input int v);
    for (int i = 0; i < 6 && m_pos != p; i++) act(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10 && m_dig[p] != v; i++) act(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic set_time(input int h, input int mi, input int s);
    set_digit(5, h / 10);  set_digit(4, h % 10);
    set_digit(3, mi / 10); set_digit(2, mi % 10);
    set_digit(1, s / 10);  set_digit(0, s % 10);
  endtask

  initial begin
    int first, nt;
    reset = 1'b1; set_mod = 1'b0; left = 1'b0; right = 1'b0; up = 1'b0; down = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset hours", hours, hexp(0));
    chk("reset seconds", seconds, 0);
    chk("reset editing", editing, 0);
    chk("reset blink", blink, 0);

    // Free run: first tick 10 cycles after release, 60 ticks in 600 cycles.
    first = 0; nt = 0;
    for (int k = 1; k <= 600; k++) begin
      act(1'b0, 1'b0, 1'b0, 1'b0);
      if (sec_tick) begin nt++; if (first == 0) first = k; end
    end
    chk("first tick cycle", first, 10);
    chk("ticks in 600", nt, 60);
    chk("run minutes", minutes, 1);
    chk("run seconds", seconds, 0);

    // Preload 23:59:58 and roll over midnight.
    set_lvl(1'b1);
    chk("enter set", editing, 1);
    set_time(23, 59, 58);
    set_lvl(1'b0);
    chk("preload hours", hours, hexp(23));
    chk("preload seconds", seconds, 58);
    nt = 0;
    for (int k = 1; k <= 20; k++) begin
      act(1'b0, 1'b0, 1'b0, 1'b0);
      if (sec_tick) nt++;
    end
    chk("wrap ticks", nt, 2);
    chk("wrap hours", hours, hexp(0));
    chk("wrap minutes", minutes, 0);

    // Hour-tens editing with clamp, cursor wrap and same-cycle conflicts.
    set_lvl(1'b1);
    act(1'b0, 1'b1, 1'b0, 1'b0); chk("right wraps to 5", edit_pos, 5);
    act(1'b0, 1'b0, 1'b1, 1'b0);
    act(1'b0, 1'b1, 1'b0, 1'b0);
    act(1'b0, 1'b0, 1'b0, 1'b1); chk("hours 19", hours, hexp(19));
    act(1'b1, 1'b0, 1'b0, 1'b0);
    act(1'b0, 1'b0, 1'b1, 1'b0); chk("19 tens up clamp", hours, hexp(23));
    act(1'b0, 1'b0, 1'b1, 1'b0); chk("23 tens up", hours, hexp(3));
    act(1'b0, 1'b0, 1'b1, 1'b0); chk("03 tens up", hours, hexp(13));
    chk("13 pm", pm, pmexp(13));
    act(1'b1, 1'b1, 1'b0, 1'b0); chk("left+right no move", edit_pos, 5);
    act(1'b0, 1'b0, 1'b1, 1'b1); chk("up+down no change", hours, hexp(13));
    act(1'b0, 1'b0, 1'b0, 1'b1); chk("13 tens down", hours, hexp(3));
    act(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) act(1'b0, 1'b0, 1'b1, 1'b0);
    chk("hours 09", hours, hexp(9));
    act(1'b1, 1'b0, 1'b0, 1'b0);
    act(1'b0, 1'b0, 1'b0, 1'b1); chk("tens down wrap clamp", hours, hexp(23));
    act(1'b1, 1'b0, 1'b0, 1'b0); chk("left wraps to 0", edit_pos, 0);
    act(1'b1, 1'b0, 1'b1, 1'b0); chk("edit+move pos", edit_pos, 1);
    chk("edit+move seconds", seconds, 1);

    // Hold SET at 12:34:56, then exit and time the first tick.
    set_time(12, 34, 56);
    set_lvl(1'b0);
    chk("commit minutes", minutes, 34);
    set_lvl(1'b1);
    nt = 0;
    for (int k = 0; k < 50; k++) begin
      act(1'b0, 1'b0, 1'b0, 1'b0);
      if (sec_tick) nt++;
    end
    chk("no tick in set", nt, 0);
    chk("hold seconds", seconds, 56);
    set_lvl(1'b0);
    first = 0;
    for (int k = 1; k <= 15; k++) begin
      act(1'b0, 1'b0, 1'b0, 1'b0);
      if (sec_tick && first == 0) first = k;
    end
    chk("tick after exit", first, 10);
    chk("exit seconds", seconds, 57);
    chk("exit hours", hours, hexp(12));

    // Reset in the middle of SET with edits pending; set_mod still high afterwards.
    set_lvl(1'b1);
    act(1'b0, 1'b0, 1'b1, 1'b0);
    act(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("mid-set reset hours", hours, hexp(0));
    chk("mid-set reset seconds", seconds, 0);
    chk("mid-set reset editing", editing, 0);
    chk("mid-set reset pos", edit_pos, 0);
    act(1'b0, 1'b0, 1'b0, 1'b0);
    chk("set after reset", editing, 1);
    set_lvl(1'b0);
    for (int k = 0; k < 12; k++) act(1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
